// File: rtl/dlx_mem_pkg.sv
// Shared types for the DLX memory access sequencer: FSM states, access sizes and byte-lane shifts.
// Used by dlx_mem_seq and dlx_mem_lane; the optional MEM_ALIGN_CHECK_EN macro affects dlx_mem_seq only.
package dlx_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        BYTE,
        HALF,
        WORD
    } size_e;

    // Big-endian lane positions: bit index of the lane's LSB within the 32-bit word.
    localparam logic [4:0] BYTE_LANE_SHIFT [4] = '{5'd24, 5'd16, 5'd8, 5'd0};
    localparam logic [4:0] HALF_LANE_SHIFT [2] = '{5'd16, 5'd0};

    function automatic size_e decode_size(input logic wr, input logic sb, input logic sh,
                                          input logic lb, input logic lh);
        if (wr) begin
            return sb ? BYTE : (sh ? HALF : WORD);
        end
        return lb ? BYTE : (lh ? HALF : WORD);
    endfunction

endpackage

// File: rtl/dlx_mem_lane.sv
// Combinational byte-lane unit: merges store data into a read word and extracts/extends load lanes.
module dlx_mem_lane
    import dlx_mem_pkg::*;
(
    input  logic  [31:0] word,
    input  logic  [31:0] wdata,
    input  size_e        size,
    input  logic  [1:0]  offset,
    input  logic         extend,
    output logic  [31:0] merged,
    output logic  [31:0] extracted
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam int          HI      = 31 - 8 * gi;
            localparam logic [1:0]  LANE    = 2'(gi);
            localparam logic        HALF_IX = 1'(gi / 2);
            localparam bit          HI_BYTE = (gi % 2 == 0);

            logic       hit;
            logic [7:0] new_byte;

            always_comb begin
                hit      = 1'b0;
                new_byte = wdata[HI -: 8];
                if (size == BYTE) begin
                    hit      = (offset == LANE);
                    new_byte = wdata[7:0];
                end else if (size == HALF) begin
                    hit      = (offset[1] == HALF_IX);
                    new_byte = HI_BYTE ? wdata[15:8] : wdata[7:0];
                end else begin
                    hit      = 1'b1;
                end
            end

            assign merged[HI -: 8] = hit ? new_byte : word[HI -: 8];
        end
    endgenerate

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = word[BYTE_LANE_SHIFT[offset] +: 8];
    assign lane_h = word[HALF_LANE_SHIFT[offset[1]] +: 16];

    always_comb begin
        extracted = word;
        if (size == BYTE) begin
            extracted = {{24{extend & lane_b[7]}}, lane_b};
        end else if (size == HALF) begin
            extracted = {{16{extend & lane_h[15]}}, lane_h};
        end
    end

endmodule

// File: rtl/dlx_mem_seq.sv
// Multi-cycle load/store sequencer between the DLX datapath and a 32-bit word memory port.
// Define MEM_ALIGN_CHECK_EN to report misaligned halfword/word accesses via rsp_err.
module dlx_mem_seq
    import dlx_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic              req_sb,
    input  logic              req_sh,
    input  logic              req_lb,
    input  logic              req_lh,
    input  logic              req_load_extend,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    state_e            state_reg;
    logic              req_ready_reg;
    logic              rsp_valid_reg;
    logic [31:0]       rsp_rdata_reg;
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [31:0]       mem_wdata_reg;

    logic              wr_reg;
    size_e             size_reg;
    logic              ext_reg;
    logic [1:0]        offset_reg;
    logic [31:0]       wdata_reg;

    size_e             req_size;
    logic              misaligned;
    logic [31:0]       merged;
    logic [31:0]       extracted;

    assign req_size = decode_size(req_wr, req_sb, req_sh, req_lb, req_lh);

`ifdef MEM_ALIGN_CHECK_EN
    logic rsp_err_reg;

    always_comb begin
        misaligned = 1'b0;
        if (req_size == HALF) begin
            misaligned = req_addr[0];
        end else if (req_size == WORD) begin
            misaligned = |req_addr[1:0];
        end
    end

    // High only during the RESP cycle that follows a rejected request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_reg <= 1'b0;
        end else begin
            rsp_err_reg <= (state_reg == IDLE) && req_valid && misaligned;
        end
    end

    assign rsp_err = rsp_err_reg;
`else
    assign misaligned = 1'b0;
    assign rsp_err    = 1'b0;
`endif

    dlx_mem_lane u_lane (
        .word      (mem_rdata),
        .wdata     (wdata_reg),
        .size      (size_reg),
        .offset    (offset_reg),
        .extend    (ext_reg),
        .merged    (merged),
        .extracted (extracted)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            wr_reg        <= 1'b0;
            size_reg      <= WORD;
            ext_reg       <= 1'b0;
            offset_reg    <= '0;
            wdata_reg     <= '0;
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        wr_reg        <= req_wr;
                        size_reg      <= req_size;
                        ext_reg       <= req_load_extend;
                        offset_reg    <= req_addr[1:0];
                        wdata_reg     <= req_wdata;
                        req_ready_reg <= 1'b0;
                        if (misaligned) begin
                            state_reg     <= RESP;
                            rsp_valid_reg <= 1'b1;
                        end else begin
                            mem_req_reg  <= 1'b1;
                            mem_addr_reg <= {req_addr[ADDR_W-1:2], 2'b00};
                            // Sub-word stores need the old word first (read-modify-write).
                            if (!req_wr || req_size != WORD) begin
                                state_reg  <= RD;
                                mem_we_reg <= 1'b0;
                            end else begin
                                state_reg     <= WR;
                                mem_we_reg    <= 1'b1;
                                mem_wdata_reg <= req_wdata;
                            end
                        end
                    end
                end
                RD: begin
                    if (mem_ack) begin
                        if (!wr_reg) begin
                            state_reg     <= RESP;
                            rsp_rdata_reg <= extracted;
                            rsp_valid_reg <= 1'b1;
                            mem_req_reg   <= 1'b0;
                        end else begin
                            state_reg     <= WR;
                            mem_we_reg    <= 1'b1;
                            mem_wdata_reg <= merged;
                        end
                    end
                end
                WR: begin
                    if (mem_ack) begin
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                        mem_req_reg   <= 1'b0;
                        mem_we_reg    <= 1'b0;
                    end
                end
                RESP: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_dlx_mem_seq.sv
// Self-checking bench for dlx_mem_seq: directed scenarios plus randomized loads/stores against a byte-level model.
// Expectations follow MEM_ALIGN_CHECK_EN when it is defined for the build.
module tb_dlx_mem_seq;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic        req_sb = 1'b0;
    logic        req_sh = 1'b0;
    logic        req_lb = 1'b0;
    logic        req_lh = 1'b0;
    logic        req_load_extend = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    dlx_mem_seq #(.ADDR_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_wr          (req_wr),
        .req_sb          (req_sb),
        .req_sh          (req_sh),
        .req_lb          (req_lb),
        .req_lh          (req_lh),
        .req_load_extend (req_load_extend),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    bus_t        bus_log [$];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          rsp_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rdata = '0;

    // Memory responder: acknowledges after ack_delay wait cycles, random data otherwise.
    always @(negedge clk) begin
        if (mem_ack) wait_cnt = 0;
        if (mem_req) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr[11:2]];
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
            wait_cnt++;
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            wait_cnt  = 0;
        end
    end

    always @(posedge clk) begin
        if (mem_req && mem_ack) bus_log.push_back(bus_t'{mem_we, mem_addr, mem_wdata});
    end

    always @(negedge clk) begin
        if (rsp_valid) rsp_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_writes(input int n0);
        for (int i = n0; i < bus_log.size(); i++)
            if (bus_log[i].we) mem[bus_log[i].addr[11:2]] = bus_log[i].wdata;
    endtask

    // Reference model: byte-position arithmetic on ref_mem; updates exp_rdata on loads.
    task automatic model_access(input bit wr, input bit sb, input bit sh, input bit lb, input bit lh,
                                input bit ext, input logic [31:0] addr, input logic [31:0] wdata,
                                input int d, output bit e_err, output int e_lat, output int e_nacc);
        int          nbytes;
        int          pos;
        int          sh_amt;
        int          idx;
        logic [31:0] valmask;
        logic [31:0] v;
        idx = int'(addr[11:2]);
        if (wr) nbytes = sb ? 1 : (sh ? 2 : 4);
        else    nbytes = lb ? 1 : (lh ? 2 : 4);
        e_err = ALIGN_CHK && ((int'(addr[1:0]) % nbytes) != 0);
        if (e_err) begin
            e_lat  = 1;
            e_nacc = 0;
            return;
        end
        pos     = (nbytes == 4) ? 0 : (int'(addr[1:0]) / nbytes) * nbytes;
        sh_amt  = 8 * (4 - pos - nbytes);
        valmask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        if (wr) begin
            ref_mem[idx] = (ref_mem[idx] & ~(valmask << sh_amt)) | ((wdata & valmask) << sh_amt);
            e_nacc = (nbytes == 4) ? 1 : 2;
            e_lat  = (nbytes == 4) ? 2 + d : 3 + 2 * d;
        end else begin
            v = (ref_mem[idx] >> sh_amt) & valmask;
            if (ext && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~valmask;
            exp_rdata = v;
            e_nacc = 1;
            e_lat  = 2 + d;
        end
    endtask

    task automatic do_access(input logic wr, input logic sb, input logic sh, input logic lb,
                             input logic lh, input logic ext, input logic [31:0] addr,
                             input logic [31:0] wdata, output int lat,
                             output logic [31:0] rdata, output logic err);
        int guard;
        @(negedge clk);
        req_wr = wr; req_sb = sb; req_sh = sh; req_lb = lb; req_lh = lh;
        req_load_extend = ext; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL accept_timeout: req_ready=%0b, required 1", req_ready);
            req_valid = 1'b0;
            lat = -1; rdata = 'x; err = 'x;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (!rsp_valid) begin
            errors++;
            $display("FAIL rsp_timeout: rsp_valid=%0b after %0d cycles, required 1", rsp_valid, lat);
        end
        rdata = rsp_rdata;
        err   = rsp_err;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 8;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %0b, required 1", req_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b, required 0", rsp_valid); end
        if (rsp_err !== 1'b0)   begin errors++; $display("FAIL reset_rsp_err: got %0b, required 0", rsp_err); end
        if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h, required 0", rsp_rdata); end
        if (mem_req !== 1'b0)   begin errors++; $display("FAIL reset_mem_req: got %0b, required 0", mem_req); end
        if (mem_we !== 1'b0)    begin errors++; $display("FAIL reset_mem_we: got %0b, required 0", mem_we); end
        if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h, required 0", mem_addr); end
        if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h, required 0", mem_wdata); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %0b, required 1", req_ready); end
        $display("reset: req_ready=%0b rsp_valid=%0b mem_req=%0b", req_ready, rsp_valid, mem_req);
    endtask

    task automatic test_word_store_load();
        int lat; logic [31:0] rd; logic er; int n0;
        ack_delay = 0;
        n0 = bus_log.size();
        do_access(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, lat, rd, er);
        apply_writes(n0);
        ref_mem[32'h100 >> 2] = 32'hDEADBEEF;
        checks += 3;
        if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d, required 2", lat); end
        if (mem[32'h100 >> 2] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem: got %h, required deadbeef", mem[32'h100 >> 2]); end
        if (bus_log.size() - n0 != 1) begin errors++; $display("FAIL sw_accesses: got %0d, required 1", bus_log.size() - n0); end
        $display("sw 0x100: lat=%0d mem=%h", lat, mem[32'h100 >> 2]);
        do_access(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, lat, rd, er);
        exp_rdata = 32'hDEADBEEF;
        checks += 2;
        if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d, required 2", lat); end
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata: got %h, required deadbeef", rd); end
        $display("lw 0x100: lat=%0d rdata=%h", lat, rd);
    endtask

    task automatic test_byte_merge();
        int lat; logic [31:0] rd; logic er; int n0;
        mem[32'h200 >> 2] = 32'h11223344;
        ref_mem[32'h200 >> 2] = 32'h11AA3344;
        n0 = bus_log.size();
        do_access(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h201, 32'h123456AA, lat, rd, er);
        apply_writes(n0);
        checks += 3;
        if (lat !== 3) begin errors++; $display("FAIL sb_latency: got %0d, required 3", lat); end
        if (bus_log.size() - n0 != 2) begin errors++; $display("FAIL sb_accesses: got %0d, required 2", bus_log.size() - n0); end
        if (mem[32'h200 >> 2] !== 32'h11AA3344) begin errors++; $display("FAIL sb_mem: got %h, required 11aa3344", mem[32'h200 >> 2]); end
        if (bus_log.size() - n0 == 2) begin
            checks += 2;
            if (bus_log[n0].we !== 1'b0 || bus_log[n0].addr !== 32'h200)
                begin errors++; $display("FAIL sb_read: got we=%0b addr=%h, required we=0 addr=00000200", bus_log[n0].we, bus_log[n0].addr); end
            if (bus_log[n0+1].we !== 1'b1 || bus_log[n0+1].wdata !== 32'h11AA3344)
                begin errors++; $display("FAIL sb_write: got we=%0b data=%h, required we=1 data=11aa3344", bus_log[n0+1].we, bus_log[n0+1].wdata); end
        end
        $display("sb 0x201: lat=%0d mem=%h", lat, mem[32'h200 >> 2]);
    endtask

    task automatic test_subword_loads();
        logic [31:0] addrs [3] = '{32'h300, 32'h300, 32'h302};
        bit          is_lb [3] = '{1'b1, 1'b1, 1'b0};
        bit          exts  [3] = '{1'b1, 1'b0, 1'b1};
        logic [31:0] exps  [3] = '{32'hFFFFFF80, 32'h00000080, 32'h00007F01};
        int lat; logic [31:0] rd; logic er;
        mem[32'h300 >> 2] = 32'h80FF7F01;
        ref_mem[32'h300 >> 2] = 32'h80FF7F01;
        for (int i = 0; i < 3; i++) begin
            do_access(1'b0, 1'b0, 1'b0, is_lb[i], !is_lb[i], exts[i], addrs[i], $urandom, lat, rd, er);
            exp_rdata = exps[i];
            checks += 2;
            if (rd !== exps[i]) begin errors++; $display("FAIL subload_rdata[%0d]: got %h, required %h", i, rd, exps[i]); end
            if (lat !== 2) begin errors++; $display("FAIL subload_latency[%0d]: got %0d, required 2", i, lat); end
            $display("subload %0d addr=%h rdata=%h lat=%0d", i, addrs[i], rd, lat);
        end
    endtask

    task automatic test_stall();
        logic [31:0] addr = 32'h144;
        mem[addr >> 2] = 32'hCAFE0123;
        ref_mem[addr >> 2] = 32'hCAFE0123;
        ack_delay = 5;
        @(negedge clk);
        req_wr = 1'b0; req_lb = 1'b0; req_lh = 1'b0; req_sb = 1'b0; req_sh = 1'b0;
        req_addr = addr; req_valid = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_idle: got %0b, required 1", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr = $urandom;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== addr || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got mem_req=%0b addr=%h ready=%0b rsp_valid=%0b, required 1 %h 0 0",
                         c, mem_req, mem_addr, req_ready, rsp_valid, addr);
            end
            @(negedge clk);
        end
        exp_rdata = 32'hCAFE0123;
        checks += 2;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_rsp_valid: got %0b, required 1", rsp_valid); end
        if (rsp_rdata !== 32'hCAFE0123) begin errors++; $display("FAIL stall_rdata: got %h, required cafe0123", rsp_rdata); end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_pulse: got %0b, required 0", rsp_valid); end
        ack_delay = 0;
        $display("stall load: rdata=%h", rsp_rdata);
    endtask

    task automatic test_misaligned();
        int lat; logic [31:0] rd; logic er; int n0;
        logic [31:0] prev = exp_rdata;
        n0 = bus_log.size();
        do_access(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h101, 32'h0, lat, rd, er);
        checks += 4;
        if (ALIGN_CHK) begin
            if (er !== 1'b1) begin errors++; $display("FAIL mis_err: got %0b, required 1", er); end
            if (lat !== 1) begin errors++; $display("FAIL mis_latency: got %0d, required 1", lat); end
            if (rd !== prev) begin errors++; $display("FAIL mis_rdata: got %h, required %h", rd, prev); end
            if (bus_log.size() != n0) begin errors++; $display("FAIL mis_accesses: got %0d, required 0", bus_log.size() - n0); end
        end else begin
            exp_rdata = 32'hFFFFDEAD;
            if (er !== 1'b0) begin errors++; $display("FAIL mis_err: got %0b, required 0", er); end
            if (lat !== 2) begin errors++; $display("FAIL mis_latency: got %0d, required 2", lat); end
            if (rd !== 32'hFFFFDEAD) begin errors++; $display("FAIL mis_rdata: got %h, required ffffdead", rd); end
            if (bus_log.size() - n0 != 1) begin errors++; $display("FAIL mis_accesses: got %0d, required 1", bus_log.size() - n0); end
        end
        $display("lh 0x101: err=%0b lat=%0d rdata=%h", er, lat, rd);
    endtask

    task automatic test_reset_mid();
        int n0; int rsp_before;
        ack_delay = 1000;
        n0 = bus_log.size();
        @(negedge clk);
        req_wr = 1'b1; req_sb = 1'b0; req_sh = 1'b0;
        req_addr = 32'h180; req_wdata = 32'h55AA55AA; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL midrst_in_wr: got mem_req=%0b mem_we=%0b, required 1 1", mem_req, mem_we); end
        rsp_before = rsp_cnt;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL midrst_mem_req: got %0b, required 0", mem_req); end
        @(negedge clk);
        rst_n = 1'b1;
        ack_delay = 0;
        exp_rdata = 32'h0;
        checks += 2;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %0b, required 1", req_ready); end
        if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata: got %h, required 0", rsp_rdata); end
        repeat (5) @(negedge clk);
        checks += 2;
        if (rsp_cnt != rsp_before) begin errors++; $display("FAIL midrst_no_rsp: got %0d responses, required 0", rsp_cnt - rsp_before); end
        if (bus_log.size() != n0) begin errors++; $display("FAIL midrst_no_access: got %0d accesses, required 0", bus_log.size() - n0); end
        $display("reset mid-WR: mem_req=%0b req_ready=%0b", mem_req, req_ready);
    endtask

    task automatic test_random(input int n);
        int lat; logic [31:0] rd; logic er; int n0;
        bit wr, sb, sh, lb, lh, ext, e_err;
        int e_lat, e_nacc, d;
        logic [31:0] addr, wdata;
        for (int i = 0; i < n; i++) begin
            wr = $urandom_range(0, 1); sb = ($urandom_range(0, 2) == 0); sh = ($urandom_range(0, 1) == 0);
            lb = ($urandom_range(0, 2) == 0); lh = ($urandom_range(0, 1) == 0); ext = $urandom_range(0, 1);
            addr = 32'h400 + $urandom_range(0, 63); wdata = $urandom; d = $urandom_range(0, 3);
            ack_delay = d;
            n0 = bus_log.size();
            do_access(wr, sb, sh, lb, lh, ext, addr, wdata, lat, rd, er);
            apply_writes(n0);
            model_access(wr, sb, sh, lb, lh, ext, addr, wdata, d, e_err, e_lat, e_nacc);
            checks += 5;
            if (lat !== e_lat) begin errors++; $display("FAIL rand_latency[%0d]: got %0d, required %0d", i, lat, e_lat); end
            if (er !== e_err) begin errors++; $display("FAIL rand_err[%0d]: got %0b, required %0b", i, er, e_err); end
            if (rd !== exp_rdata) begin errors++; $display("FAIL rand_rdata[%0d]: got %h, required %h", i, rd, exp_rdata); end
            if (bus_log.size() - n0 != e_nacc) begin errors++; $display("FAIL rand_accesses[%0d]: got %0d, required %0d", i, bus_log.size() - n0, e_nacc); end
            if (mem[addr[11:2]] !== ref_mem[addr[11:2]]) begin errors++; $display("FAIL rand_mem[%0d]: got %h, required %h", i, mem[addr[11:2]], ref_mem[addr[11:2]]); end
            if (e_nacc > 0 && bus_log.size() > n0) begin
                checks++;
                if (bus_log[n0].addr !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL rand_addr[%0d]: got %h, required %h", i, bus_log[n0].addr, {addr[31:2], 2'b00}); end
            end
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rand_b2b[%0d]: got rsp_valid=%0b req_ready=%0b, required 0 1", i, rsp_valid, req_ready); end
            $display("rand %0d: wr=%0b addr=%h lat=%0d err=%0b rdata=%h", i, wr, addr, lat, er, rd);
        end
        ack_delay = 0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_word_store_load();
        test_byte_merge();
        test_subword_loads();
        test_stall();
        test_misaligned();
        test_reset_mid();
        test_random(150);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dlx_mem_seq.md
# dlx_mem_seq

Multi-cycle memory access sequencer between the DLX datapath and a single 32-bit word-wide data memory port. It accepts one load or store per handshake, using the decoder's `mem_wr`, `sb`, `sh`, `lb`, `lh` and `load_extend` signals. Byte and halfword stores are performed as read-modify-write. Byte and halfword loads are returned extracted and zero- or sign-extended. Memory is big-endian: byte offset 0 is bits [31:24].

## Interface
- ADDR_W, 32, byte address width.
- clk  in  1  clock; all state is updated on the rising edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- req_valid  in  1  access request.
- req_ready  out  1  sequencer can accept a request (high only in IDLE).
- req_wr  in  1  store (1) or load (0).
- req_sb, req_sh  in  1  byte / halfword store; neither set means word store.
- req_lb, req_lh  in  1  byte / halfword load; neither set means word load.
- req_load_extend  in  1  1 = sign-extend a sub-word load, 0 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; the sub-word value sits in the low bits.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  load result; holds its value until the next load completes.
- rsp_err  out  1  misaligned access; valid together with rsp_valid.
- mem_req  out  1  memory access request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  word address (bits [1:0] always 0).
- mem_wdata  out  32  memory write data.
- mem_ack  in  1  memory completion; mem_rdata is valid in the same cycle as mem_ack.
- mem_rdata  in  32  memory read data.

## Operation
- States: IDLE, RD, WR, RESP.
- Handshake: a request is accepted when req_valid and req_ready are both high on a clock edge. At acceptance, the address, write data and all flags are registered.
- Access size priority:
  - Stores: sb beats sh, which beats word.
  - Loads: lb beats lh, which beats word.
  - Load flags are ignored when req_wr=1; store flags are ignored when req_wr=0.
- Transitions from IDLE on acceptance:
  - misaligned access goes to RESP;
  - load or sub-word store goes to RD;
  - word store goes to WR.
- RD:
  - mem_req=1, mem_we=0.
  - On mem_ack, a load goes to RESP with the extracted result registered into rsp_rdata.
  - On mem_ack, a sub-word store goes to WR with the merged word registered.
- WR:
  - mem_req=1, mem_we=1, mem_wdata = merged word (sub-word store) or the captured data (word store).
  - On mem_ack, go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then return to IDLE.
- Byte lanes:
  - Byte offset k occupies bits [31-8k : 24-8k].
  - Halfword offset 0 occupies [31:16]; offset 2 occupies [15:0].
- Merge: only the addressed lane of the read word is replaced with the low byte or low half of the write data.
- Extract: the addressed lane is moved to the low bits. The upper bits are the lane's MSB when load_extend=1, and 0 otherwise.
- mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack. A memory that never acknowledges stalls the sequencer indefinitely.
- Errors: rsp_err=1 means no memory access was made and rsp_rdata is unchanged.

## Timing
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0.
- Reset asserted mid-access drops mem_req immediately (asynchronously) and discards the access. No response is produced.
- Minimum latency from acceptance edge to rsp_valid, with mem_ack high in the first cycle of each access:
  - load or word store: 2 cycles;
  - sub-word store: 3 cycles;
  - misaligned access: 1 cycle.
- Back-to-back: the earliest next acceptance is the cycle after RESP.
- mem_ack is ignored in IDLE and RESP.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - halfword access at an odd address, or word access with addr[1:0]≠0, completes with rsp_err=1;
  - no memory access is made.
- MEM_ALIGN_CHECK_EN undefined:
  - halfword accesses use addr[1] only; word accesses ignore addr[1:0];
  - rsp_err is tied to 0.

## Structure
- Package dlx_mem_pkg holds:
  - the state enum;
  - the access-size encoding (BYTE, HALF, WORD);
  - byte-lane shift constants.
- Sub-module dlx_mem_lane is purely combinational. It provides merge (old word, data, size, offset → new word) and extract (word, size, offset, extend → result). It is instantiated once.

## Test plan
- Word store then word load: store 0xDEADBEEF to 0x100, then load 0x100 → memory word at 0x100 is 0xDEADBEEF and rsp_rdata=0xDEADBEEF; each access has 2-cycle latency with immediate ack.
- Byte merge: memory word at 0x200 = 0x11223344; sb 0xAA to 0x201 → one read then one write of 0x11AA3344, rsp_valid 3 cycles after acceptance.
- Sub-word loads from word 0x80FF7F01 at 0x300:
  - lb at 0x300 with extend=1 → 0xFFFFFF80;
  - lbu at 0x300 (extend=0) → 0x00000080;
  - lh at 0x302 with extend=1 → 0x00007F01.
- Stall: mem_ack held low for 5 cycles on a load → mem_req and mem_addr stay stable throughout and req_ready stays 0; rsp_valid follows 1 cycle after the ack.
- Misaligned access with MEM_ALIGN_CHECK_EN defined: lh at 0x101 → rsp_err=1 one cycle after acceptance, mem_req never asserted. Without the macro: the same lh reads the word at 0x100 and returns half offset 0.
- Reset mid-access: rst_n pulled low while in WR → mem_req is 0 in the same cycle; after release, state is IDLE, req_ready=1, and no rsp_valid is seen.
